// File: rtl/route_split_pkg.sv
// Shared definitions for the two-channel pulse router pair (transmit and receive sides).
package route_split_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_FRAME_LEN = 8;
    localparam int DEF_A_SLOTS   = 4;
    localparam int DEF_CNT_W     = 4;

    // Width of a slot index able to hold 0..n-1 (never less than one bit).
    function automatic int slot_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/route_split_cnt.sv
// Per-channel saturating pulse accumulator; slot 0 restarts the frame count.
module route_split_cnt
    import route_split_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_nxt
);

    logic [CNT_W-1:0] acc;

    // Count stops at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Next count: slot 0 loads this slot's pulse, other slots add it with saturation.
    always_comb begin
        cnt_nxt = acc;
        if (load)
            cnt_nxt = CNT_W'(inc);
        else if (inc)
            cnt_nxt = sat_inc(acc);
    end

    // Accumulator register; the next value is also exported so the frame total
    // can include the final slot's pulse without an extra cycle.
    always_ff @(posedge clk) begin
        if (!rstn)
            acc <= '0;
        else
            acc <= cnt_nxt;
    end

endmodule

// File: rtl/route_split.sv
// Splits a slot-multiplexed pulse line back into channel A/B pulses with per-frame counts.
module route_split
    import route_split_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int A_SLOTS   = DEF_A_SLOTS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             TI,
    input  logic             RSTN,
    input  logic             SYNC,
    input  logic             ABI,
    output logic             AO,
    output logic             BO,
    output logic [CNT_W-1:0] ACNT,
    output logic [CNT_W-1:0] BCNT,
    output logic             CVALID,
    output logic             ERR
);

    localparam int SW = slot_w(FRAME_LEN);
    localparam logic [SW-1:0] A_IDX = SW'(A_SLOTS);
    localparam logic [SW-1:0] LAST  = SW'(FRAME_LEN - 1);

    state_t          state, state_n;
    logic [SW-1:0]   slot, slot_n;
    logic [SW-1:0]   cur_p0;
    logic            act_p0, last_p0, err_p0;
    logic            pa_p0, pb_p0, ld_p0;
    logic [CNT_W-1:0] a_nxt, b_nxt;
    logic            ao_p1, bo_p1, cv_p1, err_p1;
    logic [CNT_W-1:0] acnt_p1, bcnt_p1;

    // Framing FSM: decide which slot this cycle represents and whether it is processed.
    always_comb begin
        state_n = state;
        slot_n  = slot;
        cur_p0  = slot;
        act_p0  = 1'b0;
        err_p0  = 1'b0;
        case (state)
            HUNT: begin
                if (SYNC) begin
                    state_n = RUN;
                    act_p0  = 1'b1;
                    cur_p0  = '0;
                end
            end
            RUN: begin
                if (SYNC && slot != '0) begin
                    // early marker: drop the partial frame and restart at slot 0
                    err_p0 = 1'b1;
                    act_p0 = 1'b1;
                    cur_p0 = '0;
                end else if (!SYNC && slot == '0) begin
                    // marker absent at the wrap: lose lock, drop this slot
                    err_p0  = 1'b1;
                    state_n = HUNT;
                    slot_n  = '0;
                end else begin
                    act_p0 = 1'b1;
                end
            end
            default: begin
                state_n = HUNT;
                slot_n  = '0;
            end
        endcase
        if (act_p0)
            slot_n = (cur_p0 == LAST) ? '0 : cur_p0 + SW'(1);
    end

    // Stage p0: channel decode of the processed slot.
    assign pa_p0   = act_p0 & ABI & (cur_p0 <  A_IDX);
    assign pb_p0   = act_p0 & ABI & (cur_p0 >= A_IDX);
    assign ld_p0   = act_p0 & (cur_p0 == '0);
    assign last_p0 = act_p0 & (cur_p0 == LAST);

    route_split_cnt #(.CNT_W(CNT_W)) u_cnt_a (
        .clk     (TI),
        .rstn    (RSTN),
        .load    (ld_p0),
        .inc     (pa_p0),
        .cnt_nxt (a_nxt)
    );

    route_split_cnt #(.CNT_W(CNT_W)) u_cnt_b (
        .clk     (TI),
        .rstn    (RSTN),
        .load    (ld_p0),
        .inc     (pb_p0),
        .cnt_nxt (b_nxt)
    );

    // FSM state and slot counter registers.
    always_ff @(posedge TI) begin
        if (!RSTN) begin
            state <= HUNT;
            slot  <= '0;
        end else begin
            state <= state_n;
            slot  <= slot_n;
        end
    end

    // Stage p1: registered pulses, frame counts, strobes.
    always_ff @(posedge TI) begin
        if (!RSTN) begin
            ao_p1   <= 1'b0;
            bo_p1   <= 1'b0;
            cv_p1   <= 1'b0;
            err_p1  <= 1'b0;
            acnt_p1 <= '0;
            bcnt_p1 <= '0;
        end else begin
            ao_p1  <= pa_p0;
            bo_p1  <= pb_p0;
            cv_p1  <= last_p0;
            err_p1 <= err_p0;
            if (last_p0) begin
                acnt_p1 <= a_nxt;
                bcnt_p1 <= b_nxt;
            end
        end
    end

    assign AO     = ao_p1;
    assign BO     = bo_p1;
    assign CVALID = cv_p1;
    assign ERR    = err_p1;
    assign ACNT   = acnt_p1;
    assign BCNT   = bcnt_p1;

endmodule

// File: tb/tb_route_split.sv
// Self-checking bench for route_split: directed frames plus randomized traffic vs a frame model.
module tb_route_split;

    localparam int FL   = 8;
    localparam int AS   = 4;
    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          TI = 1'b0;
    logic          RSTN, SYNC, ABI;
    logic          AO, BO, CVALID, ERR;
    logic [CW-1:0] ACNT, BCNT;

    int chk_total = 0;
    int chk_pass  = 0;

    // model state
    bit in_lock;
    int pos;
    bit fbits [FL];
    int e_ao, e_bo, e_cv, e_err, e_acnt, e_bcnt;

    route_split #(.FRAME_LEN(FL), .A_SLOTS(AS), .CNT_W(CW)) dut (
        .TI     (TI),
        .RSTN   (RSTN),
        .SYNC   (SYNC),
        .ABI    (ABI),
        .AO     (AO),
        .BO     (BO),
        .ACNT   (ACNT),
        .BCNT   (BCNT),
        .CVALID (CVALID),
        .ERR    (ERR)
    );

    always #5 TI = ~TI;

    task automatic check(input string tag, input int obs, input int exp);
        chk_total++;
        if (obs == exp)
            chk_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Frame-level reference: which slot (if any) this cycle is, and what the outputs become.
    task automatic predict(input bit s, input bit a, input bit r);
        int p;
        int na, nb;
        e_ao = 0; e_bo = 0; e_cv = 0; e_err = 0;
        if (!r) begin
            in_lock = 0; pos = 0; e_acnt = 0; e_bcnt = 0;
            foreach (fbits[i]) fbits[i] = 0;
            return;
        end
        p = -1;
        if (!in_lock) begin
            if (s) begin p = 0; in_lock = 1; end
        end else if (s && pos != 0) begin
            e_err = 1; p = 0;
        end else if (!s && pos == 0) begin
            e_err = 1; in_lock = 0;
        end else begin
            p = pos;
        end
        if (p < 0) begin
            pos = 0;
            return;
        end
        if (p == 0) foreach (fbits[i]) fbits[i] = 0;
        fbits[p] = a;
        if (a) begin
            if (p < AS) e_ao = 1; else e_bo = 1;
        end
        if (p == FL - 1) begin
            na = 0; nb = 0;
            for (int i = 0; i < FL; i++) begin
                if (i < AS) na += int'(fbits[i]); else nb += int'(fbits[i]);
            end
            e_cv = 1;
            e_acnt = (na > MAXC) ? MAXC : na;
            e_bcnt = (nb > MAXC) ? MAXC : nb;
        end
        pos = (p + 1) % FL;
    endtask

    task automatic step(input bit s, input bit a, input bit r);
        SYNC = s; ABI = a; RSTN = r;
        predict(s, a, r);
        @(posedge TI);
        #1;
        check("AO", int'(AO), e_ao);
        check("BO", int'(BO), e_bo);
        check("CVALID", int'(CVALID), e_cv);
        check("ERR", int'(ERR), e_err);
        check("ACNT", int'(ACNT), e_acnt);
        check("BCNT", int'(BCNT), e_bcnt);
    endtask

    task automatic frame(input logic [FL-1:0] pat);
        for (int i = 0; i < FL; i++) step(i == 0, pat[i], 1'b1);
    endtask

    initial begin
        int g;
        bit s, a, r;
        in_lock = 0; pos = 0;
        step(0, 0, 0);
        step(0, 1, 0);

        // pulses in slots 0,2,5, then next frame starts
        frame(8'b0010_0101);
        frame(8'b0000_0000);

        // every slot high: both counts saturate
        frame(8'b1111_1111);
        frame(8'b1000_0001);

        // early marker at slot 3, then a full frame from the resync
        step(1, 1, 1); step(0, 0, 1); step(0, 1, 1);
        step(1, 1, 1);
        for (int i = 1; i < FL; i++) step(0, i[0], 1);
        frame(8'b0110_0011);

        // missing marker at the wrap, pulses while hunting, then relock
        step(0, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 1);
        frame(8'b1100_1010);

        // reset at slot 5 with a pulse, then a clean frame
        for (int i = 0; i < 5; i++) step(i == 0, 1, 1);
        step(0, 1, 0);
        frame(8'b0001_0110);
        frame(8'b0000_0000);

        // marker never seen from reset: hunting is silent
        step(0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 1);

        // randomized traffic with occasional framing faults and resets
        g = 0;
        for (int n = 0; n < 3000; n++) begin
            s = (g == 0);
            if ($urandom_range(0, 24) == 0) s = ~s;
            a = $urandom_range(0, 1) == 1;
            r = $urandom_range(0, 149) != 0;
            step(s, a, r);
            g = (!r) ? 0 : (g + 1) % FL;
        end

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
